fetch_sequencer: RTL and testbench

// - Upstream partner of the multicycle control unit: owns the stage register (IF/ID/EX/MEM/WB), PC, instruction register and flag register.
// - Fetches one 32-bit instruction per instruction cycle over a req/ack instruction-memory port and presents opcode/state/flags to the control unit.
// - Applies the control unit's next_state and PC_src decisions.

---
 rtl/fetch_sequencer_pkg.sv | 30 +++
 rtl/fetch_sequencer_fetch_port.sv | 55 +++++
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: stage encodings, PC source
// selections and instruction field positions.
package fetch_sequencer_pkg;

   // Pipeline stage encodings seen by the control unit
   typedef enum logic [2:0] {
      IF_STAGE  = 3'd0,
      ID_STAGE  = 3'd1,
      EX_STAGE  = 3'd2,
      MEM_STAGE = 3'd3,
      WB_STAGE  = 3'd4
   } stage_e;

   // Next-PC source selections
   localparam logic [1:0] PC_SRC_INC    = 2'b00;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b10;
   localparam logic [1:0] PC_SRC_RET    = 2'b11;

   // Opcode field position inside the instruction word
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int OPCODE_W   = 6;

   // True when a 3-bit stage code names one of the five real stages
   function automatic logic is_legal_stage(input logic [2:0] code);
      return (code <= 3'd4);
   endfunction

endpackage

// File: rtl/fetch_sequencer_fetch_port.sv
// Instruction-memory handshake: holds the request until ack, counts
// unanswered request cycles, and on timeout flags a sticky error and
// drops the request for one cycle before re-requesting.
module fetch_port #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic want_fetch,   // the stage register will be IF next cycle
   input  logic in_fetch,     // the stage register is IF this cycle
   input  logic imem_ack,
   output logic imem_req,
   output logic accept,       // a fetch completes this cycle
   output logic fetch_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic             req_r;
   logic             err_r;
   logic [CNT_W-1:0] wait_cnt_r;

   // Request, timeout counter and sticky error; the timeout branch wins
   // over re-request so the request is low for exactly one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         req_r      <= 1'b0;
         err_r      <= 1'b0;
         wait_cnt_r <= CNT_ZERO;
      end else if (!want_fetch) begin
         req_r      <= 1'b0;
         wait_cnt_r <= CNT_ZERO;
      end else if (req_r && !imem_ack) begin
         if (wait_cnt_r == CNT_LAST) begin
            req_r      <= 1'b0;
            err_r      <= 1'b1;
            wait_cnt_r <= CNT_ZERO;
         end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
         end
      end else begin
         req_r      <= 1'b1;
         wait_cnt_r <= CNT_ZERO;
      end
   end

   // An ack only counts against an outstanding request during IF
   assign accept    = req_r & imem_ack & in_fetch;
   assign imem_req  = req_r;
   assign fetch_err = err_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the stage register, PC, instruction register and
// ALU flag register, fetches one instruction per instruction cycle and
// applies the control unit's next-stage and next-PC decisions.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
   parameter int                TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        next_state,
   input  logic [1:0]        PC_src,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [ADDR_W-1:0] ret_addr,
   input  logic              alu_zero,
   input  logic              alu_carry,
   input  logic              alu_neg,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [2:0]        state,
   output logic [OPCODE_W-1:0] opcode,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc,
   output logic              zeroFlag,
   output logic              carryFlag,
   output logic              negFlag,
   output logic              fetch_err
);

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   stage_e            state_r;
   stage_e            stage_next_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_mux_s;
   logic              pc_load_s;
   logic [31:0]       instr_r;
   logic              zero_r;
   logic              carry_r;
   logic              neg_r;
   logic              accept_s;
   logic              want_fetch_s;
   logic              in_fetch_s;

   assign in_fetch_s   = (state_r == IF_STAGE);
   assign want_fetch_s = (stage_next_s == IF_STAGE);

   fetch_port #(
      .TIMEOUT (TIMEOUT)
   ) u_fetch_port (
      .clk        (clk),
      .reset      (reset),
      .want_fetch (want_fetch_s),
      .in_fetch   (in_fetch_s),
      .imem_ack   (imem_ack),
      .imem_req   (imem_req),
      .accept     (accept_s),
      .fetch_err  (fetch_err)
   );

   // Next stage: IF waits for a fetch; other stages follow the control
   // unit, with any illegal code forcing a return to IF
   always_comb begin
      stage_next_s = IF_STAGE;
      pc_load_s    = 1'b0;
      case (state_r)
         IF_STAGE: begin
            if (accept_s) begin
               stage_next_s = ID_STAGE;
            end else begin
               stage_next_s = IF_STAGE;
            end
         end
         ID_STAGE, EX_STAGE, MEM_STAGE, WB_STAGE: begin
            if (is_legal_stage(next_state)) begin
               stage_next_s = stage_e'(next_state);
            end else begin
               stage_next_s = IF_STAGE;
            end
            if (next_state == 3'd0) begin
               pc_load_s = 1'b1;
            end else begin
               pc_load_s = 1'b0;
            end
         end
         default: begin
            stage_next_s = IF_STAGE;
            pc_load_s    = 1'b0;
         end
      endcase
   end

   // Next-PC selection; the increment wraps naturally at ADDR_W bits
   always_comb begin
      pc_mux_s = pc_r + PC_ONE;
      case (PC_src)
         PC_SRC_INC:    pc_mux_s = pc_r + PC_ONE;
         PC_SRC_JUMP:   pc_mux_s = jump_target;
         PC_SRC_BRANCH: pc_mux_s = branch_target;
         PC_SRC_RET:    pc_mux_s = ret_addr;
         default:       pc_mux_s = pc_r + PC_ONE;
      endcase
   end

   // Stage register and PC
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IF_STAGE;
         pc_r    <= RESET_PC;
      end else begin
         state_r <= stage_next_s;
         if (pc_load_s) begin
            pc_r <= pc_mux_s;
         end
      end
   end

   // Instruction register loads only on an accepted fetch; flags track
   // the ALU during EX so the last EX cycle's values are kept
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_r <= 32'h0000_0000;
         zero_r  <= 1'b0;
         carry_r <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         if (accept_s) begin
            instr_r <= imem_rdata;
         end
         if (state_r == EX_STAGE) begin
            zero_r  <= alu_zero;
            carry_r <= alu_carry;
            neg_r   <= alu_neg;
         end
      end
   end

   assign state     = state_r;
   assign pc        = pc_r;
   assign imem_addr = pc_r;
   assign instr     = instr_r;
   assign opcode    = instr_r[OPCODE_MSB:OPCODE_LSB];
   assign zeroFlag  = zero_r;
   assign carryFlag = carry_r;
   assign negFlag   = neg_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_fetch_sequencer;

   localparam int          ADDR_W = 16;
   localparam logic [15:0] RST_PC = 16'h0010;
   localparam int          TMO    = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  next_state;
   logic [1:0]  PC_src;
   logic [15:0] jump_target;
   logic [15:0] branch_target;
   logic [15:0] ret_addr;
   logic        alu_zero;
   logic        alu_carry;
   logic        alu_neg;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [2:0]  state;
   logic [5:0]  opcode;
   logic [31:0] instr;
   logic [15:0] pc;
   logic        zeroFlag;
   logic        carryFlag;
   logic        negFlag;
   logic        fetch_err;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RST_PC),
      .TIMEOUT  (TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .next_state    (next_state),
      .PC_src        (PC_src),
      .jump_target   (jump_target),
      .branch_target (branch_target),
      .ret_addr      (ret_addr),
      .alu_zero      (alu_zero),
      .alu_carry     (alu_carry),
      .alu_neg       (alu_neg),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .state         (state),
      .opcode        (opcode),
      .instr         (instr),
      .pc            (pc),
      .zeroFlag      (zeroFlag),
      .carryFlag     (carryFlag),
      .negFlag       (negFlag),
      .fetch_err     (fetch_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state (stage as a plain number 0..4)
   int          m_stage;
   logic [15:0] m_pc;
   logic [31:0] m_instr;
   logic [2:0]  m_flags;   // {zero, carry, neg}
   logic        m_err;
   logic        m_req;
   int          m_wait;    // request cycles gone unanswered

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      bit accepted;
      int nxt;
      if (reset) begin
         m_stage = 0; m_pc = RST_PC; m_instr = 32'h0; m_flags = 3'b000;
         m_err = 1'b0; m_req = 1'b0; m_wait = 0;
         return;
      end
      accepted = (m_stage == 0) && m_req && imem_ack;
      if (m_stage == 0) nxt = accepted ? 1 : 0;
      else              nxt = (next_state <= 3'd4) ? int'(next_state) : 0;
      if (m_stage != 0 && next_state == 3'd0) begin
         case (PC_src)
            2'd0:    m_pc = m_pc + 16'd1;
            2'd1:    m_pc = jump_target;
            2'd2:    m_pc = branch_target;
            default: m_pc = ret_addr;
         endcase
      end
      if (m_stage == 2) m_flags = {alu_zero, alu_carry, alu_neg};
      if (accepted) m_instr = imem_rdata;
      if (nxt != 0) begin
         m_req = 1'b0; m_wait = 0;
      end else if (m_req && !imem_ack) begin
         m_wait++;
         if (m_wait == TMO) begin
            m_err = 1'b1; m_req = 1'b0; m_wait = 0;
         end
      end else begin
         m_req = 1'b1; m_wait = 0;
      end
      m_stage = nxt;
   endtask

   task automatic compare_all();
      check_eq("state",     {29'd0, state},     m_stage);
      check_eq("pc",        {16'd0, pc},        {16'd0, m_pc});
      check_eq("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
      check_eq("imem_req",  {31'd0, imem_req},  {31'd0, m_req});
      check_eq("instr",     instr,              m_instr);
      check_eq("opcode",    {26'd0, opcode},    {26'd0, m_instr[31:26]});
      check_eq("flags",     {29'd0, zeroFlag, carryFlag, negFlag}, {29'd0, m_flags});
      check_eq("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
   endtask

   // One clock: model predicts, DUT clocks, outputs sampled after the edge
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      reset = 1'b1; next_state = 3'd0; PC_src = 2'd0;
      jump_target = 16'h0; branch_target = 16'h0; ret_addr = 16'h0;
      alu_zero = 1'b0; alu_carry = 1'b0; alu_neg = 1'b0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      m_stage = 0; m_pc = RST_PC; m_instr = 32'h0; m_flags = 3'b000;
      m_err = 1'b0; m_req = 1'b0; m_wait = 0;

      // Reset state
      cycle();
      check_eq("rst_state", {29'd0, state}, 32'd0);
      check_eq("rst_pc", {16'd0, pc}, 32'h0010);
      check_eq("rst_req", {31'd0, imem_req}, 32'd0);
      check_eq("rst_err", {31'd0, fetch_err}, 32'd0);
      reset = 1'b0;
      cycle();
      check_eq("req_after_rst", {31'd0, imem_req}, 32'd1);
      check_eq("addr_after_rst", {16'd0, imem_addr}, 32'h0010);

      // Ack after three wait cycles
      repeat (3) cycle();
      imem_ack = 1'b1; imem_rdata = 32'h0C00_0000;
      cycle();
      imem_ack = 1'b0;
      check_eq("fetch_instr", instr, 32'h0C00_0000);
      check_eq("fetch_opcode", {26'd0, opcode}, 32'h03);
      check_eq("fetch_state", {29'd0, state}, 32'd1);
      check_eq("fetch_pc", {16'd0, pc}, 32'h0010);

      // R-type: ID -> EX -> WB -> IF, pc advances only on WB -> IF
      next_state = 3'd2; cycle();
      check_eq("rtype_ex_pc", {16'd0, pc}, 32'h0010);
      next_state = 3'd4; cycle();
      check_eq("rtype_wb_state", {29'd0, state}, 32'd4);
      next_state = 3'd0; PC_src = 2'd0; cycle();
      check_eq("rtype_if_state", {29'd0, state}, 32'd0);
      check_eq("rtype_pc_inc", {16'd0, pc}, 32'h0011);

      // Branch taken from EX
      imem_ack = 1'b1; imem_rdata = 32'h1000_0000; cycle();
      imem_ack = 1'b0; next_state = 3'd2; cycle();
      alu_zero = 1'b1; next_state = 3'd0; PC_src = 2'd2; branch_target = 16'h0040; cycle();
      alu_zero = 1'b0;
      check_eq("branch_zero", {31'd0, zeroFlag}, 32'd1);
      check_eq("branch_pc", {16'd0, pc}, 32'h0040);

      // PC wrap at 0xFFFF
      imem_ack = 1'b1; cycle();
      imem_ack = 1'b0; PC_src = 2'd1; jump_target = 16'hFFFF; cycle();
      check_eq("jump_pc", {16'd0, pc}, 32'h0000_FFFF);
      imem_ack = 1'b1; cycle();
      imem_ack = 1'b0; PC_src = 2'd0; cycle();
      check_eq("wrap_pc", {16'd0, pc}, 32'h0000);

      // Timeout: fifteen unanswered request cycles
      repeat (TMO) cycle();
      check_eq("tmo_err", {31'd0, fetch_err}, 32'd1);
      check_eq("tmo_req_drop", {31'd0, imem_req}, 32'd0);
      cycle();
      check_eq("tmo_rereq", {31'd0, imem_req}, 32'd1);
      check_eq("tmo_addr", {16'd0, imem_addr}, 32'h0000);
      imem_ack = 1'b1; imem_rdata = 32'h2400_0001; cycle();
      imem_ack = 1'b0;
      check_eq("tmo_then_id", {29'd0, state}, 32'd1);
      check_eq("tmo_err_sticky", {31'd0, fetch_err}, 32'd1);

      // Illegal next_state from EX
      next_state = 3'd2; cycle();
      next_state = 3'd6; PC_src = 2'd1; jump_target = 16'h1234; cycle();
      check_eq("illegal_state", {29'd0, state}, 32'd0);
      check_eq("illegal_pc", {16'd0, pc}, 32'h0000);

      // Reset during an outstanding request, late ack ignored
      next_state = 3'd0;
      reset = 1'b1; cycle();
      reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; cycle();
      imem_ack = 1'b0;
      check_eq("late_ack_instr", instr, 32'h0000_0000);
      check_eq("late_ack_err", {31'd0, fetch_err}, 32'd0);

      // Randomized traffic with occasional stall windows and resets
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 9) == 0) next_state = 3'($urandom_range(5, 7));
         else                           next_state = 3'($urandom_range(0, 4));
         PC_src        = 2'($urandom_range(0, 3));
         jump_target   = 16'($urandom);
         branch_target = 16'($urandom);
         ret_addr      = 16'($urandom);
         alu_zero      = 1'($urandom_range(0, 1));
         alu_carry     = 1'($urandom_range(0, 1));
         alu_neg       = 1'($urandom_range(0, 1));
         imem_rdata    = $urandom;
         if ((i % 400) < 40) imem_ack = 1'b0;
         else                imem_ack = ($urandom_range(0, 2) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
